xrv_lsu: RTL and testbench

Load/store unit; the responder side of the pipeline's is_ls/ls_done handshake. It accepts one load or store from EX and runs one transaction on the data-memory bus. It aligns store data, extracts and extends load data, and detects misaligned, illegal and timed-out accesses. It pulses ls_done exactly once per accepted access, which releases the pipeline stall.

---
 rtl/xrv_pkg.sv | 29 ++
 rtl/xrv_lsu_align.sv | 81 ++++++++
 rtl/xrv_lsu.sv | 218 +++++++++++++++++++++
 tb/tb_xrv_lsu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrv_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, fault causes.
package xrv_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Fault cause codes reported on ls_cause
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

endpackage

// File: rtl/xrv_lsu_align.sv
// Combinational lane logic: store byte-enables/replication, alignment and funct3
// legality checks for a new request, and load byte/halfword extract and extend.
module xrv_lsu_align
    import xrv_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    input  logic [2:0]  rsp_funct3_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Request side: lane mask, replicated store data and fault detection
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = 32'h0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        if (is_store_i) begin
            case (funct3_i)
                F3_SB: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o      = {2{wdata_i[15:0]}};
                    misaligned_o = addr_lo_i[0];
                end
                F3_SW: begin
                    be_o         = 4'b1111;
                    wdata_o      = wdata_i;
                    misaligned_o = |addr_lo_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_LB, F3_LBU: be_o = 4'b0001 << addr_lo_i;
                F3_LH, F3_LHU: begin
                    be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    misaligned_o = addr_lo_i[0];
                end
                F3_LW: begin
                    be_o         = 4'b1111;
                    misaligned_o = |addr_lo_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

    // Response side: pick the addressed lane and sign- or zero-extend it
    always_comb begin
        case (rsp_addr_lo_i)
            2'd0:    rbyte = rdata_i[7:0];
            2'd1:    rbyte = rdata_i[15:8];
            2'd2:    rbyte = rdata_i[23:16];
            default: rbyte = rdata_i[31:24];
        endcase
        rhalf = rsp_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (rsp_funct3_i)
            F3_LB:   rdata_o = {{24{rbyte[7]}}, rbyte};
            F3_LBU:  rdata_o = {24'h0, rbyte};
            F3_LH:   rdata_o = {{16{rhalf[15]}}, rhalf};
            F3_LHU:  rdata_o = {16'h0, rhalf};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/xrv_lsu.sv
// Load/store unit: accepts one access from EX, runs it on the data bus with a
// bounded timeout and reports completion with a single ls_done pulse.
module xrv_lsu
    import xrv_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_ls,
    input  logic        flush,
    input  logic        ls_is_store,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [4:0]  ls_rd,
    output logic        ls_done,
    output logic        ls_err,
    output logic [1:0]  ls_cause,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int            CW      = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(BUS_TIMEOUT - 1);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_store_q, is_store_d;
    logic          kill_q, kill_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    addr_lo_q, addr_lo_d;

    logic          ls_done_q, ls_done_d;
    logic          ls_err_q, ls_err_d;
    logic [1:0]    ls_cause_q, ls_cause_d;
    logic          wb_en_q, wb_en_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [31:0]   dmem_addr_q, dmem_addr_d;
    logic [3:0]    dmem_be_q, dmem_be_d;
    logic [31:0]   dmem_wdata_q, dmem_wdata_d;

    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic          al_misaligned;
    logic          al_illegal;
    logic [31:0]   al_rdata;
    logic          to_hit;

    xrv_lsu_align u_align (
        .is_store_i    (ls_is_store),
        .funct3_i      (ls_funct3),
        .addr_lo_i     (ls_addr[1:0]),
        .wdata_i       (ls_wdata),
        .be_o          (al_be),
        .wdata_o       (al_wdata),
        .misaligned_o  (al_misaligned),
        .illegal_o     (al_illegal),
        .rsp_funct3_i  (funct3_q),
        .rsp_addr_lo_i (addr_lo_q),
        .rdata_i       (dmem_rdata),
        .rdata_o       (al_rdata)
    );

    assign to_hit = (cnt_q == TO_LAST);

    // Next-state and registered-output logic; completion fields default to a single-cycle pulse
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        is_store_d   = is_store_q;
        kill_d       = kill_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        ls_done_d    = 1'b0;
        ls_err_d     = 1'b0;
        ls_cause_d   = CAUSE_NONE;
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (is_ls && !flush) begin
                    is_store_d = ls_is_store;
                    funct3_d   = ls_funct3;
                    addr_lo_d  = ls_addr[1:0];
                    wb_rd_d    = ls_rd;
                    kill_d     = 1'b0;
                    if (al_misaligned) begin
                        state_d    = ST_DONE;
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_cause_d = CAUSE_MISALIGN;
                    end else if (al_illegal) begin
                        state_d    = ST_DONE;
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d      = ST_REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ls_is_store;
                        dmem_addr_d  = {ls_addr[31:2], 2'b00};
                        dmem_be_d    = al_be;
                        dmem_wdata_d = al_wdata;
                    end
                end
            end
            ST_REQ: begin
                cnt_d  = cnt_q + CW'(1);
                kill_d = kill_q | flush;
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (is_store_q) begin
                        state_d   = ST_DONE;
                        ls_done_d = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (to_hit) begin
                    dmem_req_d = 1'b0;
                    state_d    = ST_DONE;
                    ls_done_d  = 1'b1;
                    ls_err_d   = 1'b1;
                    ls_cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_RESP: begin
                cnt_d  = cnt_q + CW'(1);
                kill_d = kill_q | flush;
                if (dmem_rvalid) begin
                    state_d   = ST_DONE;
                    ls_done_d = 1'b1;
                    wb_en_d   = !(kill_q || flush);
                    wb_data_d = al_rdata;
                end else if (to_hit) begin
                    state_d    = ST_DONE;
                    ls_done_d  = 1'b1;
                    ls_err_d   = 1'b1;
                    ls_cause_d = CAUSE_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and output registers; reset clears every output and aborts the access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            ls_done_q    <= 1'b0;
            ls_err_q     <= 1'b0;
            ls_cause_q   <= CAUSE_NONE;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'h0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_be_q    <= 4'h0;
            dmem_wdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            ls_done_q    <= ls_done_d;
            ls_err_q     <= ls_err_d;
            ls_cause_q   <= ls_cause_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    // Request fields only matter while an access is in flight
    always_ff @(posedge clk) begin
        is_store_q <= is_store_d;
        funct3_q   <= funct3_d;
        addr_lo_q  <= addr_lo_d;
    end

    assign ls_done    = ls_done_q;
    assign ls_err     = ls_err_q;
    assign ls_cause   = ls_cause_q;
    assign wb_en      = wb_en_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_xrv_lsu.sv
// Scoreboard bench for xrv_lsu: stimulus pushes expected completions and bus
// transfers; monitors pop and compare when ls_done or dmem_req&dmem_gnt appear.
module tb_xrv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_ls, flush, ls_is_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic [4:0]  ls_rd;
    logic        ls_done, ls_err, wb_en;
    logic [1:0]  ls_cause;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_t;

    done_t done_q[$];
    bus_t  bus_q[$];

    xrv_lsu #(.BUS_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .is_ls       (is_ls),
        .flush       (flush),
        .ls_is_store (ls_is_store),
        .ls_funct3   (ls_funct3),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_rd       (ls_rd),
        .ls_done     (ls_done),
        .ls_err      (ls_err),
        .ls_cause    (ls_cause),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Completion monitor
    always @(negedge clk) begin
        done_t e;
        if (!rst && ls_done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'(ls_done), 32'd0);
            end else begin
                e = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("ls_err", 32'(ls_err), 32'(e.err));
                check("ls_cause", 32'(ls_cause), 32'(e.cause));
                check("wb_en", 32'(wb_en), 32'(e.wb_en));
                if (e.wb_en) begin
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    // Bus transfer monitor
    always @(negedge clk) begin
        bus_t b;
        if (!rst && dmem_req && dmem_gnt) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 32'(dmem_req), 32'd0);
            end else begin
                b = bus_q.pop_front();
                check("dmem_we", 32'(dmem_we), 32'(b.we));
                check("dmem_addr", dmem_addr, b.addr);
                check("dmem_be", 32'(dmem_be), 32'(b.be));
                if (b.chk_wdata) check("dmem_wdata", dmem_wdata, b.wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic fl);
        is_ls       = 1'b1;
        flush       = fl;
        ls_is_store = st;
        ls_funct3   = f3;
        ls_addr     = addr;
        ls_wdata    = wd;
        ls_rd       = rd;
    endtask

    task automatic idle_in();
        is_ls = 1'b0;
        flush = 1'b0;
    endtask

    // Load with gnt in cycle 1 and rvalid in cycle 3
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic [31:0] exp, input logic [3:0] be);
        issue(1'b0, f3, addr, 32'h5555_AAAA, rd, 1'b0);
        done_q.push_back('{err: 1'b0, cause: 2'b00, wb_en: 1'b1, rd: rd, data: exp, cyc: cyc + 4});
        bus_q.push_back('{we: 1'b0, addr: {addr[31:2], 2'b00}, be: be, wdata: 32'h0, chk_wdata: 1'b0});
        tick(); idle_in(); dmem_gnt = 1'b1;
        check("load_req_c1", 32'(dmem_req), 32'd1);
        tick(); dmem_gnt = 1'b0;
        check("load_req_drop", 32'(dmem_req), 32'd0);
        tick(); dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick(); dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        tick(); tick();
    endtask

    // Store with gnt held low for 'wait_n' cycles
    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             input int wait_n, input logic [3:0] be, input logic [31:0] lane);
        issue(1'b1, f3, addr, wd, 5'd9, 1'b0);
        done_q.push_back('{err: 1'b0, cause: 2'b00, wb_en: 1'b0, rd: 5'd0, data: 32'h0, cyc: cyc + wait_n + 2});
        bus_q.push_back('{we: 1'b1, addr: {addr[31:2], 2'b00}, be: be, wdata: lane, chk_wdata: 1'b1});
        tick(); idle_in();
        for (int i = 0; i < wait_n; i++) begin
            check("store_wait_req", 32'(dmem_req), 32'd1);
            check("store_wait_be", 32'(dmem_be), 32'(be));
            check("store_wait_wdata", dmem_wdata, lane);
            check("store_wait_addr", dmem_addr, {addr[31:2], 2'b00});
            tick();
        end
        dmem_gnt = 1'b1;
        tick(); dmem_gnt = 1'b0;
        check("store_req_drop", 32'(dmem_req), 32'd0);
        tick(); tick();
    endtask

    // Access that faults in IDLE: never requests the bus, completes in cycle 1
    task automatic run_fault(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [1:0] cause);
        issue(st, f3, addr, 32'h0, 5'd3, 1'b0);
        done_q.push_back('{err: 1'b1, cause: cause, wb_en: 1'b0, rd: 5'd0, data: 32'h0, cyc: cyc + 1});
        tick(); idle_in();
        check("fault_no_req_c1", 32'(dmem_req), 32'd0);
        tick();
        check("fault_no_req_c2", 32'(dmem_req), 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        ls_is_store = 1'b0; ls_funct3 = 3'd0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        tick(); tick(); tick();
        check("rst_ls_done", 32'(ls_done), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_outputs", {dmem_addr | dmem_wdata | wb_data}, 32'd0);
        check("rst_misc", {21'd0, dmem_be, wb_rd, ls_cause}, 32'd0);
        rst = 1'b0;
        tick();

        // Loads: word, signed/unsigned byte, unsigned halfword
        run_load(3'd2, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
        run_load(3'd0, 32'h0000_2003, 5'd6, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000);
        run_load(3'd4, 32'h0000_2003, 5'd7, 32'h8011_2233, 32'h0000_0080, 4'b1000);
        run_load(3'd5, 32'h0000_2002, 5'd8, 32'h8011_2233, 32'h0000_8011, 4'b1100);
        run_load(3'd1, 32'h0000_2000, 5'd10, 32'h8011_A233, 32'hFFFF_A233, 4'b0011);

        // Stores: halfword with stalled grant, byte, word
        run_store(3'd1, 32'h0000_1002, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
        run_store(3'd0, 32'h0000_1001, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5);
        run_store(3'd2, 32'h0000_1004, 32'h1122_3344, 1, 4'b1111, 32'h1122_3344);

        // Faults
        run_fault(1'b0, 3'd2, 32'h0000_1001, 2'b01);
        run_fault(1'b1, 3'd2, 32'h0000_1002, 2'b01);
        run_fault(1'b0, 3'd1, 32'h0000_1003, 2'b01);
        run_fault(1'b0, 3'd7, 32'h0000_1000, 2'b11);
        run_fault(1'b1, 3'd3, 32'h0000_1000, 2'b11);

        // is_ls killed by same-cycle flush
        issue(1'b0, 3'd2, 32'h0000_3000, 32'h0, 5'd4, 1'b1);
        tick(); idle_in();
        check("flush_no_req_c1", 32'(dmem_req), 32'd0);
        check("flush_no_done_c1", 32'(ls_done), 32'd0);
        tick();
        check("flush_no_req_c2", 32'(dmem_req), 32'd0);
        check("flush_no_done_c2", 32'(ls_done), 32'd0);
        tick();

        // Flush while in RESP: completes, wb_en suppressed
        issue(1'b0, 3'd2, 32'h0000_3000, 32'h0, 5'd11, 1'b0);
        done_q.push_back('{err: 1'b0, cause: 2'b00, wb_en: 1'b0, rd: 5'd0, data: 32'h0, cyc: cyc + 4});
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_3000, be: 4'b1111, wdata: 32'h0, chk_wdata: 1'b0});
        tick(); idle_in(); dmem_gnt = 1'b1;
        tick(); dmem_gnt = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick(); dmem_rvalid = 1'b0;
        tick(); tick();

        // Bus timeout: gnt never arrives
        issue(1'b0, 3'd2, 32'h0000_4000, 32'h0, 5'd12, 1'b0);
        done_q.push_back('{err: 1'b1, cause: 2'b10, wb_en: 1'b0, rd: 5'd0, data: 32'h0, cyc: cyc + 5});
        tick(); idle_in();
        for (int i = 1; i <= 4; i++) begin
            check("timeout_req_held", 32'(dmem_req), 32'd1);
            tick();
        end
        check("timeout_req_drop", 32'(dmem_req), 32'd0);
        tick(); dmem_gnt = 1'b1;
        tick(); dmem_gnt = 1'b0;
        check("timeout_late_gnt_req", 32'(dmem_req), 32'd0);
        check("timeout_late_gnt_done", 32'(ls_done), 32'd0);
        tick();

        // Reset while in RESP, then a stray rvalid
        issue(1'b0, 3'd2, 32'h0000_5000, 32'h0, 5'd13, 1'b0);
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_5000, be: 4'b1111, wdata: 32'h0, chk_wdata: 1'b0});
        tick(); idle_in(); dmem_gnt = 1'b1;
        tick(); dmem_gnt = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        check("rstresp_done", 32'(ls_done), 32'd0);
        check("rstresp_req", 32'(dmem_req), 32'd0);
        check("rstresp_outputs", {dmem_addr | dmem_wdata | wb_data}, 32'd0);
        tick(); dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick(); dmem_rvalid = 1'b0;
        check("stray_rvalid_done", 32'(ls_done), 32'd0);
        check("stray_rvalid_wb_en", 32'(wb_en), 32'd0);
        tick(); tick();
        check("stray_rvalid_done_late", 32'(ls_done), 32'd0);

        // A fresh load after reset still works
        run_load(3'd2, 32'h0000_6000, 5'd14, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111);

        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
